// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the UART receive datapath.
// It does four things:
//   - Generates the 16x-oversampled baud tick that drives uart_rx.
//   - Captures each completed byte, on the rising edge of rx_done_tick,
//     into a show-ahead receive FIFO.
//   - Presents the FIFO head on a valid/ready stream.
//   - Tracks overrun in a sticky flag.
// Optional feature: define UART_RX_TIMEOUT_EN to add an idle timeout
// (rx_timeout). Without it, rx_timeout is tied to 0.
module uart_rx_ctrl #(
  parameter int DIV_W         = 16,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           baud_div,
  output logic                       tick,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [7:0]                 m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  input  logic                       clr_overrun,
  input  logic                       flush,
  output logic                       rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DIV_W-1:0] cnt;
  logic             tick_q;
  logic             done_q;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [7:0]       hold_q;
  logic             overrun_q;
  logic [7:0]       mem [DEPTH];

  // Baud divider: a live compare against baud_div, so lowering it below cnt fires on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (cnt >= baud_div) begin
      cnt    <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

  // Edge detector: rx_done_tick is a multi-cycle level, so only its rising edge is a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= rx_done_tick;
  end

  assign push    = rx_done_tick & ~done_q & en;
  assign m_valid = (level_q != '0);
  assign pop     = m_valid & m_ready;
  assign full    = (level_q == LW'(DEPTH));

  // Write/drop decision: a full FIFO still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_en = 1'b0;
    drop  = 1'b0;
    if (!flush && push) begin
      if (!full || pop) wr_en = 1'b1;
      else              drop  = 1'b1;
    end
  end

  // Pointer and occupancy bookkeeping; flush realigns the read side onto the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_q + LW'(wr_en) - LW'(pop);
    end
  end

  // Storage array for received bytes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy tracking guarantees unwritten entries are never shown.
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  // Head register: remembers the last byte shown so m_data holds steady (and is never X) when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= m_data;
  end

  assign m_data = m_valid ? mem[rd_ptr] : hold_q;
  assign level  = level_q;

  // Sticky overrun: a dropped byte takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (clr_overrun) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_CHARS * 160;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } to_state_e;

  to_state_e     state_q;
  to_state_e     state_d;
  logic [TW-1:0] to_cnt;
  logic          to_q;
  logic          activity;

  assign activity = push | pop | flush;

  // Timeout FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Timeout FSM next state: armed while the FIFO holds data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = ARMED;
      ARMED:   if (level_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle counter and flag: counts ticks while armed; any FIFO activity restarts the character window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      if (activity) to_q <= 1'b0;
      else if (to_cnt == TW'(TO_LIMIT)) to_q <= 1'b1;

      if (state_q == IDLE || activity) to_cnt <= '0;
      else if (en && tick_q && to_cnt != TW'(TO_LIMIT)) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign rx_timeout = to_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default parameters).
// Covers:
//   - Tick divider.
//   - Byte capture.
//   - FIFO fill/drain and overrun.
//   - Flush.
//   - Asynchronous reset.
//   - Idle timeout, when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic        tick;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [4:0]  level;
  logic        overrun;
  logic        clr_overrun;
  logic        flush;
  logic        rx_timeout;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .baud_div     (baud_div),
    .tick         (tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .flush        (flush),
    .rx_timeout   (rx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One rising edge on rx_done_tick, followed by one low cycle so the next byte is a fresh edge.
  task automatic push_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; baud_div = 16'd3; rx_done_tick = 1'b0; rx_data = 8'h00;
    m_ready = 1'b0; clr_overrun = 1'b0; flush = 1'b0;
    repeat (2) step();
    check("rst_tick", tick, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", rx_timeout, 0);
    rst = 1'b0;
    step();

    // Pushes are ignored while disabled.
    push_byte(8'h99);
    check("en0_push_ignored", level, 0);

    // Tick generator, baud_div=3: one tick every 4 cycles.
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("tick_div3_%0d", i), tick, (i % 4 == 3) ? 1 : 0);
    end
    en = 1'b0;
    step();
    check("tick_en_off", tick, 0);
    baud_div = 16'd0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("tick_div0_%0d", i), tick, 1);
    end
    baud_div = 16'd3;

    // Level held 20 cycles: exactly one push.
    rx_data = 8'hA5;
    rx_done_tick = 1'b1;
    step();
    check("cap_valid", m_valid, 1);
    check("cap_data", m_data, 8'hA5);
    check("cap_level", level, 1);
    repeat (19) step();
    check("cap_level_held", level, 1);
    rx_done_tick = 1'b0;
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("cap_pop_level", level, 0);
    check("cap_pop_valid", m_valid, 0);
    check("cap_hold_data", m_data, 8'hA5);

    // Fill to DEPTH, then one more: dropped, overrun set.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("full_level", level, 16);
    check("full_no_overrun", overrun, 0);
    push_byte(8'hFF);
    check("ovr_level", level, 16);
    check("ovr_flag", overrun, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), m_data, i);
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", level, 0);
    check("drain_valid", m_valid, 0);
    check("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_clear", overrun, 0);

    // Full FIFO, push and pop in the same cycle.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    rx_data = 8'h55;
    rx_done_tick = 1'b1;
    m_ready = 1'b1;
    step();
    rx_done_tick = 1'b0;
    m_ready = 1'b0;
    check("pp_level", level, 16);
    check("pp_overrun", overrun, 0);
    check("pp_head", m_data, 8'h11);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pp_drain_%0d", i), m_data, (i < 15) ? (8'h11 + i) : 8'h55);
      step();
    end
    m_ready = 1'b0;
    check("pp_empty", level, 0);

    // Flush with a simultaneous push: both the queue and the push vanish.
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    check("fl_pre_level", level, 3);
    rx_data = 8'h44;
    rx_done_tick = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    rx_done_tick = 1'b0;
    check("fl_level", level, 0);
    check("fl_valid", m_valid, 0);
    step();
    push_byte(8'h66);
    check("fl_after_level", level, 1);
    check("fl_after_data", m_data, 8'h66);

    // Set wins over clear: fill to DEPTH, then drop a byte while clearing.
    for (int i = 0; i < 15; i++) push_byte(8'(8'h70 + i));
    rx_data = 8'hEE;
    rx_done_tick = 1'b1;
    clr_overrun = 1'b1;
    step();
    rx_done_tick = 1'b0;
    clr_overrun = 1'b0;
    check("set_wins", overrun, 1);
    step();

    // Asynchronous reset mid-stream, away from the clock edge.
    baud_div = 16'd0;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_tick", tick, 0);
    check("arst_valid", m_valid, 0);
    check("arst_level", level, 0);
    check("arst_data", m_data, 8'h00);
    check("arst_overrun", overrun, 0);
    step();
    rst = 1'b0;
    step();

`ifdef UART_RX_TIMEOUT_EN
    begin
      int  wait_cyc;
      bit  seen;
      baud_div = 16'd0;
      en = 1'b1;
      push_byte(8'h77);
      wait_cyc = 0;
      seen = 1'b0;
      while (!seen && wait_cyc < 800) begin
        step();
        wait_cyc++;
        if (rx_timeout === 1'b1) seen = 1'b1;
      end
      check("to_seen", seen, 1);
      check("to_window", (wait_cyc >= 630 && wait_cyc <= 660) ? 1 : 0, 1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("to_cleared", rx_timeout, 0);
    end
`else
    check("to_tied_low", rx_timeout, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
